// File: rtl/series_pkg.sv
// Shared types and constants for the Taylor-series accumulator.
package series_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FINAL} state_t;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] Q016_MAX = 16'hFFFF;

  // Data bits, guard bits and one sign bit.
  function automatic int acc_w(input int guard_w);
    return DATA_W + guard_w + 1;
  endfunction
endpackage

// File: rtl/series_accumulator_if.sv
// Term stream in, saturated series result out.
interface series_accumulator_if;
  logic                          start;
  logic                          term_valid;
  logic [series_pkg::DATA_W-1:0] term_data;
  logic                          term_ready;
  logic                          busy;
  logic [series_pkg::DATA_W-1:0] sum;
  logic                          sum_valid;
  logic                          sat;

  modport master (output start, term_valid, term_data,
                  input  term_ready, busy, sum, sum_valid, sat);
  modport slave  (input  start, term_valid, term_data,
                  output term_ready, busy, sum, sum_valid, sat);
endinterface

// File: rtl/sat_clamp_u16.sv
// Signed accumulator -> unsigned Q0.16 clamp with saturation flag.
// ALT_SIGN_EN adds the negative clamp; without it acc is never negative.
module sat_clamp_u16
  import series_pkg::*;
#(
  parameter int ACC_W = 21
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] sum,
  output logic                     sat
);
  logic over;

`ifndef ALT_SIGN_EN
  logic unused_sign;
  assign unused_sign = acc[ACC_W-1];
`endif

  always_comb begin
    over = |acc[ACC_W-2:DATA_W];
    sum  = acc[DATA_W-1:0];
    sat  = 1'b0;
`ifdef ALT_SIGN_EN
    if (acc[ACC_W-1]) begin
      sum = '0;
      sat = 1'b1;
    end else if (over) begin
      sum = Q016_MAX;
      sat = 1'b1;
    end
`else
    if (over) begin
      sum = Q016_MAX;
      sat = 1'b1;
    end
`endif
  end
endmodule

// File: rtl/series_accumulator.sv
// Sums NTERMS consecutive Q0.16 terms into one saturated result.
// ALT_SIGN_EN: odd-index terms are subtracted (sin/cos series).
module series_accumulator
  import series_pkg::*;
#(
  parameter int NTERMS  = 4,
  parameter int GUARD_W = 4
) (
  input logic               clk,
  input logic               rst,
  series_accumulator_if.slave bus
);
  localparam int ACC_W = acc_w(GUARD_W);
  localparam int CNT_W = $clog2(NTERMS);

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  count;
  logic signed [ACC_W-1:0]  term_ext;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic        [DATA_W-1:0] clamp_sum;
  logic                     clamp_sat;
  logic                     accept;
  logic                     last;

  assign term_ext = $signed({{(ACC_W-DATA_W){1'b0}}, bus.term_data});
  assign accept   = bus.term_valid & bus.term_ready;
  assign last     = (count == CNT_W'(NTERMS-1));

`ifdef ALT_SIGN_EN
  assign acc_nxt = count[0] ? (acc - term_ext) : (acc + term_ext);
`else
  assign acc_nxt = acc + term_ext;
`endif

  // Clamp the post-add value so the result is registered on the last accept
  // and presented during FINAL.
  sat_clamp_u16 #(.ACC_W(ACC_W)) u_clamp (
    .acc (acc_nxt),
    .sum (clamp_sum),
    .sat (clamp_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      acc            <= '0;
      count          <= '0;
      bus.sum        <= '0;
      bus.sat        <= 1'b0;
      bus.sum_valid  <= 1'b0;
      bus.term_ready <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.sum_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          acc            <= '0;
          count          <= '0;
          state          <= ACCUM;
          bus.term_ready <= 1'b1;
          bus.busy       <= 1'b1;
        end
        ACCUM: if (accept) begin
          acc   <= acc_nxt;
          count <= count + 1'b1;
          if (last) begin
            state          <= FINAL;
            bus.term_ready <= 1'b0;
            bus.sum        <= clamp_sum;
            bus.sat        <= clamp_sat;
            bus.sum_valid  <= 1'b1;
          end
        end
        FINAL: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
